bus_pingpong_loader: RTL and testbench

- Sequences the 26-lane packed common bus for the CNN datapath.
- Accepts a serial stream of 16-bit words over a valid/ready handshake and assembles each group of 26 words into one 416-bit packed frame.
- Presents each frame on the common bus with a valid/ready handshake, using ping-pong buffering.
- Sits between the feature/weight fetch stream and the 26-lane consumer that splits the bus back into its 16-bit lanes.

---
 rtl/cnn_bus_pkg.sv | 22 ++
 rtl/bus_frame_bank.sv | 62 ++++++
 rtl/bus_pingpong_loader.sv | 76 +++++++
 tb/tb_bus_pingpong_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_bus_pkg.sv
// Shared constants, bank state type and lane-slice helper for the 26-lane packed CNN common bus.
// Also used by the bus pack/unpack blocks so every block agrees on the lane layout.
package cnn_bus_pkg;

   localparam int WORD_W = 16;
   localparam int LANES  = 26;
   localparam int BUS_W  = WORD_W * LANES;
   localparam int IDX_W  = 5;
   localparam int FCNT_W = 16;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL
   } bank_state_t;

   // Lane k lives at bits [k*WORD_W +: WORD_W]; lane 0 sits at the LSB.
   function automatic int lane_lo(input int k);
      return k * WORD_W;
   endfunction

endpackage

// File: rtl/bus_frame_bank.sv
// One frame buffer of the ping-pong pair: LANES words written one lane at a time,
// with a full flag that is raised by the last lane and cleared when the frame is drained.
module bus_frame_bank
   import cnn_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              flush,
   input  logic              clear,
   output logic [BUS_W-1:0]  data,
   output logic              full
);

   bank_state_t state;
   logic        wr_last;

   assign wr_last = (wr_idx == IDX_W'(LANES - 1));

   // Flush only resets the bookkeeping; stale lanes are overwritten by the next fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         state <= BANK_EMPTY;
         full  <= 1'b0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
               data[lane_lo(k) +: WORD_W] <= wr_data;
            end
         end
         case (state)
            BANK_EMPTY: begin
               if (wr_en) begin
                  state <= BANK_FILLING;
               end
            end
            BANK_FILLING: begin
               if (flush) begin
                  state <= BANK_EMPTY;
               end else if (wr_en && wr_last) begin
                  state <= BANK_FULL;
                  full  <= 1'b1;
               end
            end
            BANK_FULL: begin
               if (clear) begin
                  state <= BANK_EMPTY;
                  full  <= 1'b0;
               end
            end
            default: begin
               state <= BANK_EMPTY;
               full  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bus_pingpong_loader.sv
// Assembles a serial stream of 16-bit words into 26-lane packed frames and presents them
// on the common bus through two ping-pong banks, so filling and draining can overlap.
module bus_pingpong_loader
   import cnn_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [BUS_W-1:0]  com_bus_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  fill_level,
   output logic [FCNT_W-1:0] frame_cnt
);

   logic              wr_bank;
   logic              rd_bank;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        full;
   logic [BUS_W-1:0]  bank_data [2];
   logic              in_hs;
   logic              out_hs;
   logic              wr_last;

   assign in_ready    = !full[wr_bank] && !flush;
   assign in_hs       = in_valid && in_ready;
   assign out_valid   = full[rd_bank];
   assign out_hs      = out_valid && out_ready;
   assign wr_last     = (idx == IDX_W'(LANES - 1));
   assign com_bus_out = bank_data[rd_bank];
   assign fill_level  = idx;

   // A fill only ever targets a non-full bank and a drain only a full one,
   // so both can be honoured in the same cycle without conflict.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      bus_frame_bank u_bank (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (in_hs && (wr_bank == 1'(b))),
         .wr_idx  (idx),
         .wr_data (in_data),
         .flush   (flush && (wr_bank == 1'(b))),
         .clear   (out_hs && (rd_bank == 1'(b))),
         .data    (bank_data[b]),
         .full    (full[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         idx       <= '0;
         frame_cnt <= '0;
      end else begin
         if (flush) begin
            idx <= '0;
         end else if (in_hs) begin
            if (wr_last) begin
               idx     <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
         if (out_hs) begin
            rd_bank   <= ~rd_bank;
            frame_cnt <= frame_cnt + FCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bus_pingpong_loader.sv
// Self-checking bench for bus_pingpong_loader: directed scenarios plus a randomized run,
// all compared against a frame-queue reference model (partial words + queue of pending frames).
module tb_bus_pingpong_loader;
   import cnn_bus_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WORD_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              flush = 1'b0;
   logic [BUS_W-1:0]  com_bus_out;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [IDX_W-1:0]  fill_level;
   logic [FCNT_W-1:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   logic [WORD_W-1:0] part_q[$];
   logic [BUS_W-1:0]  pend_q[$];
   int                delivered = 0;

   bus_pingpong_loader dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .com_bus_out (com_bus_out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fill_level  (fill_level),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   // Two frame slots exist, so a word is takeable whenever fewer than two frames wait.
   function automatic bit exp_ready();
      return (pend_q.size() < 2) && !flush;
   endfunction

   function automatic logic [IDX_W-1:0] exp_fill();
      return IDX_W'(part_q.size());
   endfunction

   function automatic logic [FCNT_W-1:0] exp_cnt();
      return FCNT_W'(delivered);
   endfunction

   task automatic set_inputs(input bit v, input logic [WORD_W-1:0] d, input bit f, input bit r);
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
      #1;
   endtask

   task automatic tick();
      bit               acc;
      bit               drn;
      logic [BUS_W-1:0] fr;
      acc = in_valid && exp_ready();
      drn = out_ready && (pend_q.size() > 0);
      @(posedge clk);
      if (rst) begin
         part_q.delete();
         pend_q.delete();
         delivered = 0;
      end else begin
         if (drn) begin
            void'(pend_q.pop_front());
            delivered++;
         end
         if (flush) begin
            part_q.delete();
         end else if (acc) begin
            part_q.push_back(in_data);
            if (part_q.size() == LANES) begin
               fr = '0;
               for (int k = 0; k < LANES; k++) fr[16*k +: 16] = part_q[k];
               pend_q.push_back(fr);
               part_q.delete();
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      set_inputs(0, '0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      set_inputs(0, '0, 0, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++; if (com_bus_out !== '0) begin bad++; $display("[TB] FAIL reset_bus: got %h want 0", com_bus_out); end
      total++; if (fill_level !== '0) begin bad++; $display("[TB] FAIL reset_fill: got %0d want 0", fill_level); end
      total++; if (frame_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", frame_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_single_frame();
      apply_reset();
      for (int k = 0; k < LANES; k++) begin
         set_inputs(1, 16'(k), 0, 1);
         total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_in_ready: word %0d got %0b want 1", k, in_ready); end
         total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid: word %0d got %0b want 0", k, out_valid); end
         tick();
      end
      set_inputs(0, '0, 0, 1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_latency: got %0b want 1", out_valid); end
      for (int k = 0; k < LANES; k++) begin
         total++; if (com_bus_out[16*k +: 16] !== 16'(k)) begin bad++; $display("[TB] FAIL single_lane%0d: got %0d want %0d", k, com_bus_out[16*k +: 16], k); end
      end
      tick();
      set_inputs(0, '0, 0, 0);
      total++; if (frame_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_cnt: got %0d want 1", frame_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drained: got %0b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [WORD_W-1:0] lane0_q[$];
      apply_reset();
      for (int i = 0; i < 3 * LANES + 3; i++) begin
         set_inputs(i < 3 * LANES, 16'(100 + i), 0, 1);
         if (i < 3 * LANES) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready: cycle %0d got %0b want 1", i, in_ready); end
         end
         total++; if (out_valid !== (pend_q.size() > 0)) begin bad++; $display("[TB] FAIL b2b_out_valid: cycle %0d got %0b want %0b", i, out_valid, pend_q.size() > 0); end
         if (out_valid === 1'b1) lane0_q.push_back(com_bus_out[15:0]);
         tick();
      end
      total++; if (lane0_q.size() != 3) begin bad++; $display("[TB] FAIL b2b_frames: got %0d want 3", lane0_q.size()); end
      for (int f = 0; f < 3 && f < lane0_q.size(); f++) begin
         total++; if (lane0_q[f] !== 16'(100 + 26 * f)) begin bad++; $display("[TB] FAIL b2b_lane0_f%0d: got %0d want %0d", f, lane0_q[f], 100 + 26 * f); end
      end
      total++; if (frame_cnt !== 16'd3) begin bad++; $display("[TB] FAIL b2b_cnt: got %0d want 3", frame_cnt); end
   endtask

   task automatic test_backpressure();
      int  nacc;
      bit  a;
      nacc = 0;
      apply_reset();
      for (int i = 0; i < 60; i++) begin
         set_inputs(1, 16'(500 + nacc), 0, 0);
         total++; if (in_ready !== exp_ready()) begin bad++; $display("[TB] FAIL bp_in_ready: cycle %0d got %0b want %0b", i, in_ready, exp_ready()); end
         if (pend_q.size() > 0) begin
            total++; if (com_bus_out !== pend_q[0]) begin bad++; $display("[TB] FAIL bp_hold: cycle %0d got %h want %h", i, com_bus_out, pend_q[0]); end
         end
         a = exp_ready();
         tick();
         if (a) nacc++;
      end
      set_inputs(1, 16'(500 + nacc), 0, 0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_stall_ready: got %0b want 0", in_ready); end
      total++; if (fill_level !== '0) begin bad++; $display("[TB] FAIL bp_stall_fill: got %0d want 0", fill_level); end
      set_inputs(0, '0, 0, 1);
      total++; if (out_valid !== 1'b1 || com_bus_out[15:0] !== 16'd500) begin bad++; $display("[TB] FAIL bp_frame1: got v=%0b lane0=%0d want v=1 lane0=500", out_valid, com_bus_out[15:0]); end
      tick();
      total++; if (out_valid !== 1'b1 || com_bus_out[15:0] !== 16'd526) begin bad++; $display("[TB] FAIL bp_frame2: got v=%0b lane0=%0d want v=1 lane0=526", out_valid, com_bus_out[15:0]); end
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_resume: got %0b want 1", in_ready); end
      total++; if (frame_cnt !== 16'd2) begin bad++; $display("[TB] FAIL bp_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_flush();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         set_inputs(1, 16'(50 + i), 0, 1);
         tick();
      end
      set_inputs(1, 16'hBEEF, 1, 1);
      total++; if (fill_level !== 5'd10) begin bad++; $display("[TB] FAIL flush_fill_before: got %0d want 10", fill_level); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready: got %0b want 0", in_ready); end
      tick();
      set_inputs(0, '0, 0, 1);
      total++; if (fill_level !== '0) begin bad++; $display("[TB] FAIL flush_fill_after: got %0d want 0", fill_level); end
      for (int i = 0; i < LANES; i++) begin
         set_inputs(1, 16'(200 + i), 0, 0);
         tick();
      end
      set_inputs(0, '0, 0, 0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_frame_valid: got %0b want 1", out_valid); end
      total++; if (com_bus_out[15:0] !== 16'd200 || com_bus_out[16*25 +: 16] !== 16'd225) begin bad++; $display("[TB] FAIL flush_frame_lanes: got lane0=%0d lane25=%0d want 200/225", com_bus_out[15:0], com_bus_out[16*25 +: 16]); end
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      for (int i = 0; i < LANES + 7; i++) begin
         set_inputs(1, 16'($urandom_range(1, 65535)), 0, 0);
         tick();
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_valid: got %0b want 1", out_valid); end
      rst = 1'b1;
      set_inputs(1, 16'h1234, 0, 0);
      tick();
      rst = 1'b0;
      set_inputs(0, '0, 0, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid: got %0b want 0", out_valid); end
      total++; if (com_bus_out !== '0) begin bad++; $display("[TB] FAIL mid_bus: got %h want 0", com_bus_out); end
      total++; if (fill_level !== '0) begin bad++; $display("[TB] FAIL mid_fill: got %0d want 0", fill_level); end
      total++; if (frame_cnt !== '0) begin bad++; $display("[TB] FAIL mid_cnt: got %0d want 0", frame_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_flush_last();
      apply_reset();
      for (int i = 0; i < LANES - 1; i++) begin
         set_inputs(1, 16'(700 + i), 0, 1);
         tick();
      end
      set_inputs(1, 16'd725, 1, 1);
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flast_in_ready: got %0b want 0", in_ready); end
      tick();
      for (int i = 0; i < 3; i++) begin
         set_inputs(0, '0, 0, 1);
         total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flast_no_frame: cycle %0d got %0b want 0", i, out_valid); end
         tick();
      end
      total++; if (fill_level !== '0) begin bad++; $display("[TB] FAIL flast_fill: got %0d want 0", fill_level); end
      total++; if (frame_cnt !== '0) begin bad++; $display("[TB] FAIL flast_cnt: got %0d want 0", frame_cnt); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         set_inputs($urandom_range(0, 3) != 0, 16'($urandom()), $urandom_range(0, 49) == 0, $urandom_range(0, 4) < 3);
         total++; if (in_ready !== exp_ready()) begin bad++; $display("[TB] FAIL rnd_in_ready: cycle %0d got %0b want %0b", i, in_ready, exp_ready()); end
         total++; if (out_valid !== (pend_q.size() > 0)) begin bad++; $display("[TB] FAIL rnd_out_valid: cycle %0d got %0b want %0b", i, out_valid, pend_q.size() > 0); end
         total++; if (fill_level !== exp_fill()) begin bad++; $display("[TB] FAIL rnd_fill: cycle %0d got %0d want %0d", i, fill_level, exp_fill()); end
         total++; if (frame_cnt !== exp_cnt()) begin bad++; $display("[TB] FAIL rnd_cnt: cycle %0d got %0d want %0d", i, frame_cnt, exp_cnt()); end
         if (pend_q.size() > 0) begin
            total++; if (com_bus_out !== pend_q[0]) begin bad++; $display("[TB] FAIL rnd_bus: cycle %0d got %h want %h", i, com_bus_out, pend_q[0]); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midframe();
      test_flush_last();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
